// File: rtl/dma_rd_arbiter_pkg.sv
// rtl/dma_rd_arbiter_pkg.sv - shared state encodings, DMA size codes and burst beat count for dma_rd_arbiter
package dma_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CTRL = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [2:0] SIZE_DWORD = 3'b011;

  // Word-sized bursts pack two 32-bit words per 64-bit beat; the +1 wraps in len_w bits.
  function automatic logic [63:0] burst_beats(input logic [63:0] length, input logic [2:0] size,
                                              input int unsigned len_w);
    logic [63:0] mask;
    mask = (len_w >= 64) ? '1 : ((64'd1 << len_w) - 64'd1);
    if (size == SIZE_WORD) return ((length + 64'd1) & mask) >> 1;
    return length & mask;
  endfunction

endpackage

// File: rtl/dma_rd_arbiter_rr_arb2.sv
// rtl/dma_rd_arbiter_rr_arb2.sv - two-input round-robin pick with registered last grant
module dma_rd_arbiter_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       update_id,
  output logic       any,
  output logic       pick
);

  logic last_grant;

  assign any = |req;

  always_comb begin
    pick = 1'b0;
    if (req == 2'b11) pick = ~last_grant;
    else if (req[1])  pick = 1'b1;
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        last_grant <= 1'b1;
    else if (update) last_grant <= update_id;
  end

endmodule

// File: rtl/dma_rd_arbiter.sv
// rtl/dma_rd_arbiter.sv - round-robin share of the DMA read ctrl/chnl port between two loaders
// Optional watchdog on stalled data bursts: DMA_RD_ARB_WDOG_EN.
module dma_rd_arbiter
  import dma_rd_arbiter_pkg::*;
#(
  parameter int LEN_W       = 32,
  parameter int DATA_W      = 64,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req_valid,
  input  logic [LEN_W-1:0]  r0_req_index,
  input  logic [LEN_W-1:0]  r0_req_length,
  input  logic [2:0]        r0_req_size,
  output logic              r0_req_ready,
  output logic              r0_chnl_valid,
  input  logic              r0_chnl_ready,
  input  logic              r1_req_valid,
  input  logic [LEN_W-1:0]  r1_req_index,
  input  logic [LEN_W-1:0]  r1_req_length,
  input  logic [2:0]        r1_req_size,
  output logic              r1_req_ready,
  output logic              r1_chnl_valid,
  input  logic              r1_chnl_ready,
  output logic [DATA_W-1:0] rd_chnl_data,
  output logic              dma_read_ctrl_valid,
  output logic [LEN_W-1:0]  dma_read_ctrl_data_index,
  output logic [LEN_W-1:0]  dma_read_ctrl_data_length,
  output logic [2:0]        dma_read_ctrl_data_size,
  input  logic              dma_read_ctrl_ready,
  input  logic              dma_read_chnl_valid,
  input  logic [DATA_W-1:0] dma_read_chnl_data,
  output logic              dma_read_chnl_ready,
  output logic              busy,
  output logic              grant_id,
  output logic              wdog_err
);

  arb_state_t       state, state_d;
  logic             grant_d, ctrl_valid_d;
  logic [LEN_W-1:0] index_d, length_d, beats, beats_d, count, count_d;
  logic [LEN_W-1:0] index_sel, length_sel;
  logic [2:0]       size_d, size_sel;
  logic [1:0]       req_ready_q, req_ready_d;
  logic             any, pick, lg_update, lg_id;
  logic             in_data, beat, wdog_trip;

  dma_rd_arbiter_rr_arb2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       ({r1_req_valid, r0_req_valid}),
    .update    (lg_update),
    .update_id (lg_id),
    .any       (any),
    .pick      (pick)
  );

  assign index_sel  = pick ? r1_req_index  : r0_req_index;
  assign length_sel = pick ? r1_req_length : r0_req_length;
  assign size_sel   = pick ? r1_req_size   : r0_req_size;

  assign in_data             = (state == ARB_DATA);
  assign r0_chnl_valid       = in_data && !grant_id && dma_read_chnl_valid;
  assign r1_chnl_valid       = in_data &&  grant_id && dma_read_chnl_valid;
  assign dma_read_chnl_ready = in_data && (grant_id ? r1_chnl_ready : r0_chnl_ready);
  assign rd_chnl_data        = in_data ? dma_read_chnl_data : '0;
  assign beat                = dma_read_chnl_valid && dma_read_chnl_ready;
  assign busy                = (state != ARB_IDLE);
  assign r0_req_ready        = req_ready_q[0];
  assign r1_req_ready        = req_ready_q[1];
  assign lg_id               = (state == ARB_IDLE) ? pick : grant_id;

  always_comb begin
    state_d      = state;
    grant_d      = grant_id;
    ctrl_valid_d = dma_read_ctrl_valid;
    index_d      = dma_read_ctrl_data_index;
    length_d     = dma_read_ctrl_data_length;
    size_d       = dma_read_ctrl_data_size;
    req_ready_d  = 2'b00;
    beats_d      = beats;
    count_d      = count;
    lg_update    = 1'b0;
    case (state)
      ARB_IDLE: begin
        // Hold off while a zero-length accept pulse is out, so it is not accepted twice.
        if (any && (req_ready_q == 2'b00)) begin
          grant_d = pick;
          if (length_sel == '0) begin
            req_ready_d[pick] = 1'b1;
            lg_update         = 1'b1;
          end else begin
            ctrl_valid_d = 1'b1;
            index_d      = index_sel;
            length_d     = length_sel;
            size_d       = size_sel;
            beats_d      = LEN_W'(burst_beats(64'(length_sel), size_sel, LEN_W));
            state_d      = ARB_CTRL;
          end
        end
      end
      ARB_CTRL: begin
        if (dma_read_ctrl_ready) begin
          req_ready_d[grant_id] = 1'b1;
          ctrl_valid_d          = 1'b0;
          index_d               = '0;
          length_d              = '0;
          size_d                = '0;
          count_d               = '0;
          state_d               = ARB_DATA;
        end
      end
      ARB_DATA: begin
        if (beat) begin
          if (count == beats - 1'b1) begin
            state_d   = ARB_IDLE;
            count_d   = '0;
            lg_update = 1'b1;
          end else begin
            count_d = count + 1'b1;
          end
        end else if (wdog_trip) begin
          state_d   = ARB_IDLE;
          count_d   = '0;
          lg_update = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                     <= ARB_IDLE;
      grant_id                  <= 1'b0;
      dma_read_ctrl_valid       <= 1'b0;
      dma_read_ctrl_data_index  <= '0;
      dma_read_ctrl_data_length <= '0;
      dma_read_ctrl_data_size   <= '0;
      req_ready_q               <= 2'b00;
      beats                     <= '0;
      count                     <= '0;
    end else begin
      state                     <= state_d;
      grant_id                  <= grant_d;
      dma_read_ctrl_valid       <= ctrl_valid_d;
      dma_read_ctrl_data_index  <= index_d;
      dma_read_ctrl_data_length <= length_d;
      dma_read_ctrl_data_size   <= size_d;
      req_ready_q               <= req_ready_d;
      beats                     <= beats_d;
      count                     <= count_d;
    end
  end

`ifdef DMA_RD_ARB_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_err_q;

  assign wdog_trip = in_data && !beat && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
  assign wdog_err  = wdog_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt   <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      if (!in_data || beat || wdog_trip) wdog_cnt <= '0;
      else                               wdog_cnt <= wdog_cnt + 1'b1;
      if (wdog_trip) wdog_err_q <= 1'b1;
    end
  end
`else
  assign wdog_trip = 1'b0;
  assign wdog_err  = (WDOG_CYCLES < 0);
`endif

endmodule
